// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the RV32I IF stage: a direct-mapped BTB with an
// optional 2-bit saturating history counter per entry. It predicts
// combinationally from PC_IF, is trained by the resolved branch in EX, and
// keeps saturating branch / misprediction statistics for the debug path.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter bit USE_BHT    = 1'b1,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           PC_IF,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    input  logic                  upd_valid,
    input  logic [31:0]           upd_pc,
    input  logic                  upd_taken,
    input  logic [31:0]           upd_target,
    input  logic                  upd_pred_taken,
    input  logic [31:0]           upd_pred_target,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];
    logic [1:0]       cnt_d    [ENTRIES];

    logic [STAT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [STAT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0]      if_tag, upd_tag;
    logic                  if_hit, upd_hit, upd_en;

    // Byte-offset bits of the update PC never reach the table.
    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^upd_pc[1:0];

    assign if_idx  = PC_IF[INDEX_BITS+1:2];
    assign if_tag  = PC_IF[31:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[31:INDEX_BITS+2];
    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    // Reset wins over a concurrent update so nothing is written while it is held.
    assign upd_en  = upd_valid && !rst;

    // IF lookup: reads pre-edge table contents only, no bypass from the EX write.
    always_comb begin
        pred_taken = if_hit;
        if (USE_BHT) begin
            pred_taken = if_hit && cnt_q[if_idx][1];
        end
        pred_target = pred_taken ? target_q[if_idx] : (PC_IF + 32'd4);
    end

    // EX misprediction: wrong direction, or taken with the wrong target.
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    // Table training from the resolved branch.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (upd_en) begin
            if (upd_taken) begin
                target_d[upd_idx] = upd_target;
                if (upd_hit) begin
                    if (cnt_q[upd_idx] != 2'b11) begin
                        cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
                    end
                end else begin
                    // Allocation evicts whatever aliased into this slot.
                    valid_d[upd_idx] = 1'b1;
                    tag_d[upd_idx]   = upd_tag;
                    cnt_d[upd_idx]   = 2'b10;
                end
            end else if (upd_hit) begin
                if (USE_BHT) begin
                    if (cnt_q[upd_idx] != 2'b00) begin
                        cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
                    end
                end else begin
                    valid_d[upd_idx] = 1'b0;
                end
            end
        end
    end

    // Saturating statistics; they stick at all-ones rather than wrapping.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd_en) begin
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + STAT_ONE;
            end
            if (mispredict && (mispredict_count_q != '1)) begin
                mispredict_count_d = mispredict_count_q + STAT_ONE;
            end
        end
    end

    // Valid bits, history counters and statistics with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b00;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            cnt_q              <= cnt_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Tags and targets are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: two instances (default build, and a small
// 4-entry 1-bit build with 4-bit statistics) share the same stimulus and are
// compared every cycle against a table-level reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if, upd_pc, upd_target, upd_pred_target;
    logic        upd_valid, upd_taken, upd_pred_taken;

    logic        pt0, mp0;
    logic [31:0] ptg0, bc0, mc0;
    logic        pt1, mp1;
    logic [31:0] ptg1;
    logic [3:0]  bc1, mc1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6), .USE_BHT(1'b1), .STAT_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .PC_IF(pc_if),
        .pred_taken(pt0), .pred_target(ptg0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mp0),
        .branch_count(bc0), .mispredict_count(mc0)
    );

    branch_predictor #(.INDEX_BITS(2), .USE_BHT(1'b0), .STAT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .PC_IF(pc_if),
        .pred_taken(pt1), .pred_target(ptg1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mp1),
        .branch_count(bc1), .mispredict_count(mc1)
    );

    // Reference model: model 0 mirrors dut0's parameters, model 1 mirrors dut1's.
    int          m_ib   [2] = '{6, 2};
    bit          m_bht  [2] = '{1'b1, 1'b0};
    longint      m_smax [2] = '{64'hFFFF_FFFF, 64'd15};
    bit          m_valid[2][64];
    int unsigned m_tag  [2][64];
    int unsigned m_tgt  [2][64];
    int          m_cnt  [2][64];
    longint      m_bc   [2];
    longint      m_mc   [2];

    function automatic int unsigned idx_of(int m, logic [31:0] pc);
        return (pc >> 2) % (1 << m_ib[m]);
    endfunction

    function automatic int unsigned tag_of(int m, logic [31:0] pc);
        return pc >> (m_ib[m] + 2);
    endfunction

    function automatic bit m_hit(int m, logic [31:0] pc);
        return m_valid[m][idx_of(m, pc)] && (m_tag[m][idx_of(m, pc)] == tag_of(m, pc));
    endfunction

    function automatic bit m_pred(int m, logic [31:0] pc);
        if (!m_hit(m, pc)) return 1'b0;
        if (m_bht[m]) return m_cnt[m][idx_of(m, pc)] >= 2;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_ptgt(int m, logic [31:0] pc);
        return m_pred(m, pc) ? m_tgt[m][idx_of(m, pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_misp();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[m][i] = 1'b0;
                m_cnt[m][i]   = 0;
            end
            m_bc[m] = 0;
            m_mc[m] = 0;
        end
    endtask

    task automatic m_update(int m, bit misp);
        int unsigned i;
        if (!upd_valid) return;
        if (m_bc[m] < m_smax[m]) m_bc[m]++;
        if (misp && m_mc[m] < m_smax[m]) m_mc[m]++;
        i = idx_of(m, upd_pc);
        if (upd_taken) begin
            if (m_hit(m, upd_pc)) begin
                m_tgt[m][i] = upd_target;
                if (m_cnt[m][i] < 3) m_cnt[m][i]++;
            end else begin
                m_valid[m][i] = 1'b1;
                m_tag[m][i]   = tag_of(m, upd_pc);
                m_tgt[m][i]   = upd_target;
                m_cnt[m][i]   = 2;
            end
        end else if (m_hit(m, upd_pc)) begin
            if (m_bht[m]) begin
                if (m_cnt[m][i] > 0) m_cnt[m][i]--;
            end else begin
                m_valid[m][i] = 1'b0;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare every output of both instances against the model (pre-edge state).
    task automatic check_model();
        chk("pt0",  {31'd0, pt0}, {31'd0, m_pred(0, pc_if)});
        chk("ptg0", ptg0, m_ptgt(0, pc_if));
        chk("mp0",  {31'd0, mp0}, {31'd0, m_misp()});
        chk("bc0",  bc0, 32'(m_bc[0]));
        chk("mc0",  mc0, 32'(m_mc[0]));
        chk("pt1",  {31'd0, pt1}, {31'd0, m_pred(1, pc_if)});
        chk("ptg1", ptg1, m_ptgt(1, pc_if));
        chk("mp1",  {31'd0, mp1}, {31'd0, m_misp()});
        chk("bc1",  {28'd0, bc1}, 32'(m_bc[1]));
        chk("mc1",  {28'd0, mc1}, 32'(m_mc[1]));
    endtask

    task automatic tick();
        bit misp;
        @(posedge clk);
        misp = m_misp();
        if (rst) begin
            m_reset();
        end else begin
            m_update(0, misp);
            m_update(1, misp);
        end
        #1;
    endtask

    task automatic do_cycle();
        @(negedge clk);
        check_model();
        tick();
    endtask

    task automatic set_upd(bit v, logic [31:0] pc, bit tk, logic [31:0] tgt,
                           bit ptk, logic [31:0] ptgt);
        upd_valid       = v;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    // Update driven with the prediction dut0 would have made for that PC.
    task automatic train(logic [31:0] pc, bit tk, logic [31:0] tgt);
        set_upd(1'b1, pc, tk, tgt, m_pred(0, pc), m_ptgt(0, pc));
        do_cycle();
    endtask

    function automatic logic [31:0] rnd_pc();
        return ({30'd0, 2'(($urandom_range(0, 3)))} << 12) |
               (32'($urandom_range(0, 31)) << 2);
    endfunction

    initial begin
        m_reset();
        rst   = 1'b1;
        pc_if = 32'h100;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check_model();
        chk("rst_pt",   {31'd0, pt0}, 32'd0);
        chk("rst_ptg",  ptg0, 32'h104);
        chk("rst_bc",   bc0, 32'd0);
        chk("rst_mc",   mc0, 32'd0);
        tick();

        // Allocation with a same-cycle lookup of the same PC.
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        @(negedge clk);
        check_model();
        chk("alloc_mp",   {31'd0, mp0}, 32'd1);
        chk("conflict_pt", {31'd0, pt0}, 32'd0);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_model();
        chk("alloc_pt",  {31'd0, pt0}, 32'd1);
        chk("alloc_ptg", ptg0, 32'h200);
        chk("alloc_bc",  bc0, 32'd1);
        chk("alloc_mc",  mc0, 32'd1);
        tick();

        // Hysteresis: 10 -> 01 -> 10 -> 11 -> 10.
        train(32'h100, 1'b0, 32'h0);
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_model();
        chk("hyst_nt_pt",  {31'd0, pt0}, 32'd0);
        chk("hyst_nt_ptg", ptg0, 32'h104);
        tick();
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_model();
        chk("hyst_st_pt",  {31'd0, pt0}, 32'd1);
        chk("hyst_st_ptg", ptg0, 32'h200);
        tick();

        // Aliasing in the 4-entry instance.
        train(32'h100, 1'b1, 32'h200);
        train(32'h110, 1'b1, 32'h300);
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        pc_if = 32'h100;
        @(negedge clk);
        check_model();
        chk("alias_evict_pt",  {31'd0, pt1}, 32'd0);
        chk("alias_evict_ptg", ptg1, 32'h104);
        tick();
        pc_if = 32'h110;
        @(negedge clk);
        check_model();
        chk("alias_new_ptg", ptg1, 32'h300);
        chk("alias_dut0_ptg", ptg0, 32'h300);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p;
            p = rnd_pc();
            rst = ($urandom_range(0, 199) == 0);
            pc_if = ($urandom_range(0, 3) == 0) ? p : rnd_pc();
            if ($urandom_range(0, 1) == 1) begin
                set_upd($urandom_range(0, 4) != 0, p, 1'($urandom_range(0, 1)),
                        rnd_pc() | 32'h8000, m_pred(0, p), m_ptgt(0, p));
            end else begin
                set_upd($urandom_range(0, 4) != 0, p, 1'($urandom_range(0, 1)),
                        rnd_pc(), 1'($urandom_range(0, 1)), rnd_pc());
            end
            if ($urandom_range(0, 9) == 0) pc_if = $urandom();
            do_cycle();
        end
        rst = 1'b0;

        // Repopulate, then reset with a live update that must be discarded.
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        rst = 1'b1;
        set_upd(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        do_cycle();
        rst = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        pc_if = 32'h100;
        @(negedge clk);
        check_model();
        chk("midrst_pt",  {31'd0, pt0}, 32'd0);
        chk("midrst_ptg", ptg0, 32'h104);
        chk("midrst_bc",  bc0, 32'd0);
        chk("midrst_mc",  mc0, 32'd0);
        tick();
        pc_if = 32'h500;
        @(negedge clk);
        check_model();
        chk("midrst_discard_ptg", ptg0, 32'h504);
        tick();

        // Saturation of the 4-bit statistics.
        for (int n = 0; n < 20; n++) begin
            set_upd(1'b1, 32'h900, 1'b1, 32'hA00, 1'b0, 32'h0);
            do_cycle();
        end
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_model();
        chk("sat_bc1", {28'd0, bc1}, 32'hF);
        chk("sat_mc1", {28'd0, mc1}, 32'hF);
        chk("sat_bc0", bc0, 32'd20);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch predictor that replaces the static PC+4 fall-through in the IF stage of the RV32I pipeline. It combines a direct-mapped branch target buffer (BTB) with an optional per-entry 2-bit branch history counter (BHT). It predicts in IF in the same cycle, is updated from the resolved branch in EX, and flags mispredictions so the hazard unit can flush. It also keeps saturating branch and misprediction statistics counters for the debug path.

Parameters:
INDEX_BITS, 6, log2 of BTB entries (64 entries by default); the index is PC[INDEX_BITS+1:2].
USE_BHT, 1, 1 = 2-bit saturating counter per entry; 0 = 1-bit mode (a hit always predicts taken).
STAT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
PC_IF  in  32  address of the instruction being fetched
pred_taken  out  1  IF prediction, combinational from PC_IF
pred_target  out  32  predicted next PC: BTB target if predicted taken, else PC_IF+4
upd_valid  in  1  EX holds a resolved conditional branch (0 during bubbles and flushes)
upd_pc  in  32  instruction address of the branch in EX (not PC+4)
upd_taken  in  1  actual branch outcome
upd_target  in  32  actual branch target
upd_pred_taken  in  1  prediction made for this branch in IF, pipelined to EX
upd_pred_target  in  32  prediction target made in IF, pipelined to EX
mispredict  out  1  combinational, EX-stage misprediction flag
branch_count  out  STAT_WIDTH  resolved branches seen
mispredict_count  out  STAT_WIDTH  mispredictions seen

Behaviour:
- Storage per entry: valid (1 bit), tag PC[31:INDEX_BITS+2], target (32 bits), cnt (2 bits; unused when USE_BHT=0).
- Reset: every valid bit is 0, every cnt is 2'b00, both statistics counters are 0. Tags and targets need no reset.
- While rst is asserted, rst overrides upd_valid and nothing is written.
- Outputs during and immediately after reset: pred_taken=0 and pred_target=PC_IF+4, because every valid bit is 0.
- Lookup (combinational, zero latency): hit = valid[idx] && (tag[idx] == PC_IF tag field).
  - USE_BHT=1: pred_taken = hit && cnt[idx][1].
  - USE_BHT=0: pred_taken = hit.
  - pred_target = pred_taken ? target[idx] : PC_IF + 4, with 32-bit wrap-around.
- Misprediction: mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
  - A not-taken branch correctly predicted not-taken is never a misprediction.
- Update on the rising edge when upd_valid=1 and rst=0, using upd_hit = lookup of upd_pc:
  - Taken, upd_hit: write target=upd_target. cnt increments, saturating at 2'b11.
  - Taken, miss: allocate the entry. Set valid=1, tag=upd_pc tag, target=upd_target, cnt=2'b10 (weakly taken). Any aliased entry is evicted.
  - Not taken, upd_hit, USE_BHT=1: cnt decrements, saturating at 2'b00. The entry stays valid.
  - Not taken, upd_hit, USE_BHT=0: clear valid.
  - Not taken, miss: no table change.
- Read/write conflict: an IF lookup and an EX update in the same cycle, to the same or a different index, both use pre-edge contents. There is no write-to-read bypass; the new state is visible from the next cycle.
- Statistics counters:
  - branch_count += 1 on every upd_valid cycle.
  - mispredict_count += 1 when mispredict=1.
  - Both saturate at all-ones and never wrap.
  - Both are cleared only by rst.
- Integration contract: the hazard unit flushes D/E on mispredict. The NPC mux selects upd_target when upd_taken is 1, and upd_pc+4 otherwise. Recovery and flushing are not done inside this block.

Test Plan:
- Reset, then PC_IF=0x100 -> pred_taken=0, pred_target=0x104, both counters 0.
- Update upd_pc=0x100, taken, target 0x200, upd_pred_taken=0 -> mispredict=1 that cycle. Next cycle PC_IF=0x100 gives pred_taken=1, pred_target=0x200, cnt=2'b10, branch_count=1, mispredict_count=1.
- USE_BHT=1 hysteresis: after the allocation above, one not-taken update gives cnt=01, predicting not taken. Two taken updates then give cnt=11. A second not-taken update gives 10, still predicting taken at 0x200.
- INDEX_BITS=2 aliasing: allocate 0x100 taken to 0x200, then 0x110 taken to 0x300 (same index). PC_IF=0x100 then misses (pred_target=0x104) and PC_IF=0x110 predicts 0x300.
- Same-cycle conflict: PC_IF=0x100 while allocating upd_pc=0x100 -> that cycle pred_taken=0. The next cycle pred_taken=1.
- Reset mid-operation with populated entries and upd_valid=1 -> all predictions fall through to PC_IF+4, counters are 0, and the update is discarded. Also drive 2^STAT_WIDTH mispredictions with STAT_WIDTH=4 -> both counters hold 4'hF.
